// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped 8N1 UART transmitter with a TX FIFO and a drained IRQ.
// Ports:
//   clk      system clock, all state on posedge
//   reset    asynchronous active-low reset
//   rd, wr   bus read/write strobes
//   addr     bus byte address (full compare against TXD_ADDR / CON_ADDR)
//   wdata    bus write data (TXD: byte in [7:0]; CON: [0] clear ovf, [1] ie)
//   rdata    combinational read data (status word on CON read, else 0)
//   uart_tx  registered serial output, idle high
//   irq      registered level interrupt: ie & FIFO empty & transmitter idle
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [31:0] TXD_ADDR     = 32'h4000_0018,
  parameter logic [31:0] CON_ADDR     = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        uart_tx,
  output logic        irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_bcnt, w_bcnt_nxt;
  logic [2:0]    r_bidx, w_bidx_nxt;
  logic [7:0]    r_sh, w_sh_nxt;
  logic          r_tx, w_tx_nxt;
  logic          r_irq;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf, r_ie;

  logic w_empty, w_full, w_busy;
  logic w_pop, w_push_req, w_push_ok, w_con_wr;
  logic w_unused;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_busy     = (r_state != S_IDLE);
  assign w_push_req = wr && (addr == TXD_ADDR);
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_con_wr   = wr && (addr == CON_ADDR);
  assign w_unused   = ^wdata[31:8];

  // Status word, read without side effects.
  assign rdata = (rd && (addr == CON_ADDR))
               ? {16'h0, 8'(r_count), 3'b000, r_ie, r_ovf, w_full, w_empty, w_busy}
               : 32'h0;

  assign uart_tx = r_tx;
  assign irq     = r_irq;

  // FIFO storage; pointers and count carry the reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= wdata[7:0];
  end

  // FIFO pointers, occupancy, and control/status bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_ie     <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push_ok) r_ovf <= 1'b1;
      if (w_con_wr) begin
        r_ie <= wdata[1];
        if (wdata[0]) r_ovf <= 1'b0;
      end
    end
  end

  // Serialiser state register plus registered line and interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_bidx  <= '0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_bidx  <= w_bidx_nxt;
      r_sh    <= w_sh_nxt;
      r_tx    <= w_tx_nxt;
      r_irq   <= r_ie && w_empty && (r_state == S_IDLE);
    end
  end

  // Serialiser next state: start bit, 8 data bits LSB first, stop bit.
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_bidx_nxt  = r_bidx;
    w_sh_nxt    = r_sh;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_sh_nxt    = r_mem[r_rd_ptr];
          w_bcnt_nxt  = BAUD_RELOAD;
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end else begin
          w_tx_nxt = 1'b1;
        end
      end
      S_START: begin
        if (r_bcnt == '0) begin
          w_tx_nxt    = r_sh[0];
          w_bidx_nxt  = 3'd0;
          w_bcnt_nxt  = BAUD_RELOAD;
          w_state_nxt = S_DATA;
        end else begin
          w_bcnt_nxt = r_bcnt - BW'(1);
        end
      end
      S_DATA: begin
        if (r_bcnt == '0) begin
          w_bcnt_nxt = BAUD_RELOAD;
          if (r_bidx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_sh_nxt   = r_sh >> 1;
            w_tx_nxt   = r_sh[1];
            w_bidx_nxt = r_bidx + 3'd1;
          end
        end else begin
          w_bcnt_nxt = r_bcnt - BW'(1);
        end
      end
      S_STOP: begin
        // Falls to IDLE for at least one cycle, stretching the stop bit by one clock.
        if (r_bcnt == '0) w_state_nxt = S_IDLE;
        else              w_bcnt_nxt  = r_bcnt - BW'(1);
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized bus traffic,
// checked every cycle against a queue-and-frame-age reference model.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] TXD   = 32'h4000_0018;
  localparam logic [31:0] CON   = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        uart_tx;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents, byte on the wire and cycles since its pop.
  logic [7:0] m_q[$];
  logic [7:0] m_byte;
  int         m_age;
  logic       m_ie, m_ovf, m_irq;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .TXD_ADDR    (TXD),
    .CON_ADDR    (CON)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .uart_tx(uart_tx),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_byte = 8'h00;
    m_age  = FRAME;
    m_ie   = 1'b0;
    m_ovf  = 1'b0;
    m_irq  = 1'b0;
  endfunction

  function automatic logic model_idle();
    return m_age >= FRAME;
  endfunction

  // Line level from frame age: bit slot k = age/CPB; 0 start, 1..8 data, 9 stop.
  function automatic logic model_tx();
    int k;
    if (m_age >= FRAME) return 1'b1;
    k = m_age / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    int n;
    n = m_q.size();
    return {16'h0, 8'(n), 3'b000, m_ie, m_ovf, (n == DEPTH), (n == 0), !model_idle()};
  endfunction

  function automatic void model_edge(input logic i_rd, input logic i_wr,
                                     input logic [31:0] i_addr, input logic [31:0] i_wdata);
    logic idle, empty, full, pop, irq_n;
    idle  = model_idle();
    empty = (m_q.size() == 0);
    full  = (m_q.size() == DEPTH);
    irq_n = m_ie && empty && idle;
    pop   = idle && !empty;
    if (pop) begin
      m_byte = m_q.pop_front();
      m_age  = 0;
    end else if (m_age < FRAME) begin
      m_age++;
    end
    if (i_wr && i_addr == TXD) begin
      if (!full || pop) m_q.push_back(i_wdata[7:0]);
      else              m_ovf = 1'b1;
    end
    if (i_wr && i_addr == CON) begin
      m_ie = i_wdata[1];
      if (i_wdata[0]) m_ovf = 1'b0;
    end
    m_irq = irq_n;
    if (i_rd) m_irq = irq_n;
  endfunction

  // One bus cycle: drive at negedge, check rdata, advance model at posedge, check outputs.
  task automatic do_cycle(input logic i_rd, input logic i_wr,
                          input logic [31:0] i_addr, input logic [31:0] i_wdata);
    rd = i_rd; wr = i_wr; addr = i_addr; wdata = i_wdata;
    #1;
    check("rdata", rdata, (i_rd && i_addr == CON) ? model_status() : 32'h0);
    @(posedge clk);
    model_edge(i_rd, i_wr, i_addr, i_wdata);
    @(negedge clk);
    check("uart_tx", 32'(uart_tx), 32'(model_tx()));
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, CON, 32'h0);
  endtask

  task automatic push(input logic [7:0] b);
    do_cycle(1'b0, 1'b1, TXD, {24'h0, b});
  endtask

  task automatic con_write(input logic [31:0] v);
    do_cycle(1'b0, 1'b1, CON, v);
  endtask

  // Asynchronous reset entered mid-cycle; line must go high before any clock edge.
  task automatic do_reset();
    rd = 1'b0; wr = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("rst_tx", 32'(uart_tx), 32'h1);
    check("rst_irq", 32'(irq), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (!(model_idle() && m_q.size() == 0) && n < max_cycles) begin
      do_cycle(1'b1, 1'b0, CON, 32'h0);
      n++;
    end
    idle_cycles(2);
  endtask

  task automatic random_phase(input int n, input int push_pct);
    int r;
    logic [31:0] junk;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < push_pct) begin
        do_cycle(1'($urandom_range(0, 1)), 1'b1, TXD, $urandom);
      end else if (r < push_pct + 3) begin
        do_cycle(1'($urandom_range(0, 1)), 1'b1, CON, $urandom);
      end else if (r < push_pct + 6) begin
        junk = $urandom;
        do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), junk, $urandom);
      end else begin
        do_cycle(1'($urandom_range(0, 1)), 1'b0, CON, 32'h0);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    idle_cycles(2);
    check("reset_status", rdata, 32'h2);

    // Single frame 0xA5.
    push(8'hA5);
    idle_cycles(FRAME + 4);

    // Four back-to-back pushes: first pops immediately, three remain queued.
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    check("b2b_count", rdata, 32'h0);
    idle_cycles(1);
    drain(400);

    // Fill while a frame is in flight, then overflow and clear.
    push(8'h11); push(8'h12); push(8'h13); push(8'h14); push(8'h15);
    push(8'h55);
    idle_cycles(1);
    con_write(32'h1);
    idle_cycles(1);

    // Push at full count on the cycle the head pops.
    for (int i = 0; i < 4 * FRAME && !model_idle(); i++) idle_cycles(1);
    push(8'h66);
    idle_cycles(2);
    drain(600);

    // Interrupt on drain, then masked.
    con_write(32'h2);
    idle_cycles(2);
    push(8'h3C);
    drain(200);
    idle_cycles(3);
    con_write(32'h0);
    idle_cycles(3);

    // Reset in the middle of data bit 3.
    push(8'hA5);
    push(8'h5A);
    for (int i = 0; i < 200 && !(m_age == 4 * CPB + 1); i++) idle_cycles(1);
    do_reset();
    idle_cycles(1);
    check("post_reset_status", rdata, 32'h2);
    idle_cycles(FRAME + 10);

    // Randomized traffic: heavy load (overflow, full+pop) and light load (irq/idle).
    random_phase(1500, 30);
    drain(800);
    random_phase(1500, 2);
    drain(800);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
